hub75_scanner: RTL



---
 rtl/panel_pkg.sv | 13 +
 rtl/hub75_scanner_if.sv | 27 ++
 rtl/bcm_dwell_timer.sv | 22 ++
 rtl/hub75_scanner.sv | 85 ++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// panel_pkg: scanner state encoding, colour channel offsets, panel geometry and frame-memory address packing
package panel_pkg;
    typedef enum logic [2:0] {RD_TOP, RD_BOT, CLK_LO, CLK_HI, LATCH, DISPLAY} scan_state_t;
    localparam int RED       = 0;
    localparam int GREEN     = 8;
    localparam int BLUE      = 16;
    localparam int HALF_ROWS = 16;
    localparam int PLANES    = 8;
    // {row[4:0], col[cols-1:0]}; the writer packs its addresses the same way
    function automatic logic [15:0] pixel_addr(input logic [4:0] row, input logic [9:0] col, input int cols);
        return (16'(row) << cols) | 16'(col);
    endfunction
endpackage

// File: rtl/hub75_scanner_if.sv
// hub75_scanner_if: frame-memory read port, bank handshake and HUB75 panel pins
// master = scanner side, slave = frame memory / panel side
interface hub75_scanner_if #(
    parameter int COLS = 5
);
    logic            selected_buffer;
    logic            actual_buffer;
    logic [4+COLS:0] rd_addr;
    logic [23:0]     rd_data;
    logic            hub_r1, hub_g1, hub_b1;
    logic            hub_r2, hub_g2, hub_b2;
    logic [3:0]      hub_addr;
    logic            hub_clk;
    logic            hub_lat;
    logic            hub_oe;
    logic            frame_start;
    modport master (
        input  selected_buffer, rd_data,
        output actual_buffer, rd_addr, hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
               hub_addr, hub_clk, hub_lat, hub_oe, frame_start
    );
    modport slave (
        output selected_buffer, rd_data,
        input  actual_buffer, rd_addr, hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
               hub_addr, hub_clk, hub_lat, hub_oe, frame_start
    );
endinterface

// File: rtl/bcm_dwell_timer.sv
// bcm_dwell_timer: loadable down-counter timing the lit period of one BCM bit plane
// ports: clk, rst; load (preload ON_UNIT<<plane - 1), en (count down), plane; zero flag
module bcm_dwell_timer
    import panel_pkg::*;
#(
    parameter int ON_UNIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [2:0] plane,
    output logic       zero
);
    logic [11:0] count;
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (load) count <= 12'((ON_UNIT << plane) - 1);
        else if (en && !zero) count <= count - 1'b1;
    end
    assign zero = count == '0;
endmodule

// File: rtl/hub75_scanner.sv
// hub75_scanner: scans the double-buffered frame memory onto a 1/16-scan HUB75 panel with 8-plane BCM
// ports: clk, rst; bus (master) = frame-memory read port, bank handshake, HUB75 pins, frame_start
module hub75_scanner
    import panel_pkg::*;
#(
    parameter int COLS    = 5,
    parameter int ON_UNIT = 4
) (
    input logic             clk,
    input logic             rst,
    hub75_scanner_if.master bus
);
    localparam int AW = 5 + COLS;
    scan_state_t     state, state_nx;
    logic [3:0]      row;
    logic [2:0]      plane;
    logic [COLS-1:0] col;
    logic [2:0]      top;
    logic [2:0]      pix;
    logic [5:0]      hold, data;
    logic [7:0]      red, green, blue;
    logic            dwell_zero, last_plane, last_row;

    assign red        = bus.rd_data[RED +: 8];
    assign green      = bus.rd_data[GREEN +: 8];
    assign blue       = bus.rd_data[BLUE +: 8];
    assign pix        = {red[plane], green[plane], blue[plane]};
    assign last_plane = plane == 3'(PLANES - 1);
    assign last_row   = row == 4'(HALF_ROWS - 1);

    bcm_dwell_timer #(.ON_UNIT(ON_UNIT)) dwell (
        .clk   (clk),
        .rst   (rst),
        .load  (state == LATCH),
        .en    (state == DISPLAY),
        .plane (plane),
        .zero  (dwell_zero)
    );

    always_comb begin
        state_nx = state == RD_TOP ? RD_BOT :
                   state == RD_BOT ? CLK_LO :
                   state == CLK_LO ? CLK_HI :
                   state == CLK_HI ? (&col ? LATCH : RD_TOP) :
                   state == LATCH  ? DISPLAY :
                   state == DISPLAY && !dwell_zero ? DISPLAY : RD_TOP;
        // bottom bits go straight from rd_data so data is set up a cycle before the hub_clk rise
        data = state == CLK_LO ? {top, pix} : hold;
        bus.rd_addr = AW'(pixel_addr({state == RD_BOT, row}, 10'(col), COLS));
        bus.hub_clk = state == CLK_HI;
        bus.hub_lat = state == LATCH;
        bus.hub_oe  = state != DISPLAY;
        {bus.hub_r1, bus.hub_g1, bus.hub_b1, bus.hub_r2, bus.hub_g2, bus.hub_b2} = data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= RD_TOP;
            row               <= '0;
            plane             <= '0;
            col               <= '0;
            top               <= '0;
            hold              <= '0;
            bus.hub_addr      <= '0;
            bus.actual_buffer <= 1'b0;
            bus.frame_start   <= 1'b0;
        end else begin
            state           <= state_nx;
            bus.frame_start <= 1'b0;
            if (state == RD_BOT) top <= pix;
            if (state == CLK_LO) hold <= data;
            if (state == CLK_HI) col <= col + 1'b1;
            if (state == LATCH) bus.hub_addr <= row;
            if (state == DISPLAY && dwell_zero) begin
                plane <= plane + 1'b1;
                if (last_plane) row <= row + 1'b1;
                // bank adoption only at the frame boundary closes the writer's swap handshake
                if (last_plane && last_row) begin
                    bus.actual_buffer <= bus.selected_buffer;
                    bus.frame_start   <= 1'b1;
                end
            end
        end
    end
endmodule
